// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side stream bundle and FIFO write port shared by the round-robin write arbiter.
// The master side holds the producers and the FIFO; the slave side is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          full;
    logic                          busy;
    logic [ID_W-1:0]               owner;

    modport master (
        output req_valid, req_last, req_data, full,
        input  req_ready, wr_en, wr_data, busy, owner
    );

    modport slave (
        input  req_valid, req_last, req_data, full,
        output req_ready, wr_en, wr_data, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// One owner per burst; a burst ends on last, on MAX_BURST beats, or when the owner idles.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input logic              wr_clk,
    input logic              wr_rst,
    fifo_wr_arbiter_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [7:0]      LastBeat = 8'(MAX_BURST - 1);
    localparam logic [ID_W-1:0] LastId   = ID_W'(NUM_REQ - 1);

    state_e          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0]    req_ready;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  found;
    logic [ID_W-1:0]       pick;
    logic [ID_W-1:0]       idx;
    logic [ID_W-1:0]       next_id;
    logic                  release_burst;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        busy      = 1'b0;
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        if (state_q == StGrant) begin
            busy               = 1'b1;
            req_ready[owner_q] = ~bus.full;
            wr_en              = bus.req_valid[owner_q] & ~bus.full;
            if (wr_en) begin
                wr_data = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign next_id = (owner_q == LastId) ? '0 : owner_q + 1'b1;

    // An idle owner only releases when the FIFO could have accepted a beat.
    always_comb begin
        release_burst = 1'b0;
        if (wr_en) begin
            release_burst = bus.req_last[owner_q] | (beat_cnt_q == LastBeat);
        end else if (!bus.full && !bus.req_valid[owner_q]) begin
            release_burst = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = StGrant;
                end
            end
            StGrant: begin
                if (wr_en) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
                if (release_burst) begin
                    rr_ptr_d = next_id;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.wr_en     = wr_en;
    assign bus.wr_data   = wr_data;
    assign bus.busy      = busy;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a MAX_BURST=4 instance and a MAX_BURST=1 instance
// fed by a shared set of counting producers.
module tb_fifo_wr_arbiter;
    logic wr_clk;
    logic wr_rst;

    fifo_wr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus  ();
    fifo_wr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus1 ();

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus.slave)
    );

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(1)) dut1 (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus1.slave)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic       sel;
    logic       full;
    logic [3:0] pen;
    int         pcnt[4];
    int         plimit[4];
    int         plast[4];
    logic [7:0] pbase[4];

    logic [3:0] pv, pl;
    logic [31:0] pd;

    logic       s_we, s_busy;
    logic [7:0] s_wd;
    logic [1:0] s_own;
    logic [3:0] s_rdy, s_vld;

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Producer i emits pbase+n on beat n; plimit caps the beat count; plast sets packet length.
    always_comb begin
        pv = '0;
        pl = '0;
        pd = '0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = pen[i] && (plimit[i] == 0 || pcnt[i] < plimit[i]);
            pl[i] = (plast[i] != 0) && ((pcnt[i] % plast[i]) == plast[i] - 1);
            pd[i*8 +: 8] = pbase[i] + 8'(pcnt[i]);
        end
        bus.req_valid  = sel ? 4'b0 : pv;
        bus1.req_valid = sel ? pv : 4'b0;
        bus.req_last   = pl;
        bus1.req_last  = pl;
        bus.req_data   = pd;
        bus1.req_data  = pd;
        bus.full       = full;
        bus1.full      = full;
    end

    task automatic step();
        @(negedge wr_clk);
        if (!sel) begin
            s_we = bus.wr_en;  s_wd = bus.wr_data;  s_own = bus.owner;
            s_busy = bus.busy; s_rdy = bus.req_ready; s_vld = bus.req_valid;
        end else begin
            s_we = bus1.wr_en;  s_wd = bus1.wr_data;  s_own = bus1.owner;
            s_busy = bus1.busy; s_rdy = bus1.req_ready; s_vld = bus1.req_valid;
        end
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (s_rdy[i] && s_vld[i]) pcnt[i]++;
        end
    endtask

    task automatic clear_producers();
        pen  = '0;
        full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pcnt[i] = 0; plimit[i] = 0; plast[i] = 0; pbase[i] = 8'(i * 16);
        end
    endtask

    task automatic test_reset();
        clear_producers();
        sel    = 1'b0;
        pen    = 4'hF;
        wr_rst = 1'b0;
        #2 wr_rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.wr_en, bus.req_ready, bus.owner, bus.wr_data} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy/wr_en/ready/owner/data got %b %b %b %0d %h want all 0",
                     bus.busy, bus.wr_en, bus.req_ready, bus.owner, bus.wr_data);
        end
        repeat (2) @(posedge wr_clk);
        #1 wr_rst = 1'b0;
        clear_producers();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d;
        pen = 4'hF;
        step();
        for (int g = 0; g < 5; g++) begin
            if (g > 0) step();
            n_checks++;
            if ({s_busy, s_we} !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_bubble g%0d: busy=%b wr_en=%b want 0 0", g, s_busy, s_we);
            end
            for (int b = 0; b < 4; b++) begin
                step();
                exp_d = 8'((g % 4) * 16 + (g / 4) * 4 + b);
                n_checks++;
                if ({s_busy, s_we, s_own, s_wd} !== {1'b1, 1'b1, 2'(g % 4), exp_d}) begin
                    n_fail++;
                    $display("FAIL rr_beat g%0d b%0d: busy=%b we=%b owner=%0d data=%h want 1 1 %0d %h",
                             g, b, s_busy, s_we, s_own, s_wd, g % 4, exp_d);
                end
            end
        end
        pen = '0;
        step();
        n_checks++;
        if ({s_busy, s_own} !== {1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL rr_owner_hold: busy=%b owner=%0d want 0 0", s_busy, s_own);
        end
        clear_producers();
    endtask

    task automatic test_single_owner();
        pbase[2] = 8'hA1; plimit[2] = 3; plast[2] = 3; pen = 4'b0100;
        step();
        n_checks++;
        if ({s_busy, s_we} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_arb: busy=%b wr_en=%b want 0 0", s_busy, s_we);
        end
        for (int b = 0; b < 3; b++) begin
            step();
            n_checks++;
            if ({s_busy, s_we, s_own, s_rdy, s_wd} !== {1'b1, 1'b1, 2'd2, 4'b0100, 8'(8'hA1 + b)}) begin
                n_fail++;
                $display("FAIL single_beat%0d: busy=%b we=%b owner=%0d rdy=%b data=%h want 1 1 2 0100 %h",
                         b, s_busy, s_we, s_own, s_rdy, s_wd, 8'(8'hA1 + b));
            end
        end
        step();
        n_checks++;
        if ({s_busy, s_we, s_own} !== {1'b0, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL single_release: busy=%b we=%b owner=%0d want 0 0 2", s_busy, s_we, s_own);
        end
        clear_producers();
    endtask

    task automatic test_full_stall();
        int beats;
        beats = 0;
        pbase[0] = 8'h50; plimit[0] = 4; pen = 4'b0001;
        step();
        for (int b = 0; b < 2; b++) begin
            step();
            beats += int'(s_we);
            n_checks++;
            if ({s_we, s_own, s_wd} !== {1'b1, 2'd0, 8'(8'h50 + b)}) begin
                n_fail++;
                $display("FAIL stall_pre%0d: we=%b owner=%0d data=%h want 1 0 %h",
                         b, s_we, s_own, s_wd, 8'(8'h50 + b));
            end
        end
        full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            beats += int'(s_we);
            n_checks++;
            if ({s_busy, s_we, s_rdy, s_own} !== {1'b1, 1'b0, 4'b0000, 2'd0}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: busy=%b we=%b rdy=%b owner=%0d want 1 0 0000 0",
                         c, s_busy, s_we, s_rdy, s_own);
            end
        end
        full = 1'b0;
        for (int b = 2; b < 4; b++) begin
            step();
            beats += int'(s_we);
            n_checks++;
            if ({s_we, s_own, s_wd} !== {1'b1, 2'd0, 8'(8'h50 + b)}) begin
                n_fail++;
                $display("FAIL stall_post%0d: we=%b owner=%0d data=%h want 1 0 %h",
                         b, s_we, s_own, s_wd, 8'(8'h50 + b));
            end
        end
        step();
        beats += int'(s_we);
        n_checks++;
        if (beats !== 4 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_total: beats=%0d busy=%b want 4 0", beats, s_busy);
        end
        clear_producers();
    endtask

    task automatic test_owner_idle();
        bit rdy1_seen;
        rdy1_seen = 1'b0;
        pbase[1] = 8'h60; plimit[1] = 2;
        pbase[3] = 8'h80; plimit[3] = 4;
        pen = 4'b1010;
        step();
        for (int b = 0; b < 2; b++) begin
            step();
            n_checks++;
            if ({s_we, s_own, s_wd} !== {1'b1, 2'd1, 8'(8'h60 + b)}) begin
                n_fail++;
                $display("FAIL idle_owner1_b%0d: we=%b owner=%0d data=%h want 1 1 %h",
                         b, s_we, s_own, s_wd, 8'(8'h60 + b));
            end
        end
        step();
        n_checks++;
        if ({s_busy, s_we, s_own} !== {1'b1, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL idle_detect: busy=%b we=%b owner=%0d want 1 0 1", s_busy, s_we, s_own);
        end
        step();
        rdy1_seen |= s_rdy[1];
        n_checks++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_bubble: busy=%b want 0", s_busy);
        end
        for (int b = 0; b < 4; b++) begin
            step();
            rdy1_seen |= s_rdy[1];
            n_checks++;
            if ({s_we, s_own, s_wd} !== {1'b1, 2'd3, 8'(8'h80 + b)}) begin
                n_fail++;
                $display("FAIL idle_owner3_b%0d: we=%b owner=%0d data=%h want 1 3 %h",
                         b, s_we, s_own, s_wd, 8'(8'h80 + b));
            end
        end
        step();
        rdy1_seen |= s_rdy[1];
        n_checks++;
        if (rdy1_seen !== 1'b0 || pcnt[1] !== 2) begin
            n_fail++;
            $display("FAIL idle_no_ready1: ready1_seen=%b req1_beats=%0d want 0 2", rdy1_seen, pcnt[1]);
        end
        clear_producers();
    endtask

    task automatic test_max_burst_one();
        sel = 1'b1;
        pbase[0] = 8'hC0; pbase[1] = 8'hD0;
        plast[0] = 1; plast[1] = 1;
        pen = 4'b0011;
        for (int g = 0; g < 4; g++) begin
            step();
            n_checks++;
            if ({s_busy, s_we} !== 2'b00) begin
                n_fail++;
                $display("FAIL mb1_bubble g%0d: busy=%b we=%b want 0 0", g, s_busy, s_we);
            end
            step();
            n_checks++;
            if ({s_we, s_own, s_wd} !== {1'b1, 2'(g % 2), 8'((g % 2) * 16 + 8'hC0 + g / 2)}) begin
                n_fail++;
                $display("FAIL mb1_beat g%0d: we=%b owner=%0d data=%h want 1 %0d %h", g, s_we, s_own,
                         s_wd, g % 2, 8'((g % 2) * 16 + 8'hC0 + g / 2));
            end
        end
        pen = '0;
        step();
        clear_producers();
        sel = 1'b0;
    endtask

    task automatic test_reset_abort();
        pbase[2] = 8'h90; pen = 4'b0100;
        for (int c = 0; c < 7; c++) step();
        n_checks++;
        if ({s_busy, s_we, s_own} !== {1'b1, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL abort_pre: busy=%b we=%b owner=%0d want 1 1 2", s_busy, s_we, s_own);
        end
        #2 wr_rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.wr_en, bus.req_ready, bus.owner, bus.wr_data} !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_async: busy/we/ready/owner/data got %b %b %b %0d %h want all 0",
                     bus.busy, bus.wr_en, bus.req_ready, bus.owner, bus.wr_data);
        end
        repeat (3) @(posedge wr_clk);
        #1 wr_rst = 1'b0;
        clear_producers();
        pen = 4'hF;
        step();
        step();
        n_checks++;
        if ({s_busy, s_we, s_own, s_wd} !== {1'b1, 1'b1, 2'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL abort_first_grant: busy=%b we=%b owner=%0d data=%h want 1 1 0 00",
                     s_busy, s_we, s_own, s_wd);
        end
        clear_producers();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_owner();
        test_full_stall();
        test_owner_idle();
        test_max_burst_one();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
